// File: rtl/pulse_qual_pkg.sv
// Shared constants, width helper and default types for the pulse-width qualifier
// and its round-robin event scheduler.
package pulse_qual_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_THRESH_100M = 100;   // 1 us at 100 MHz

    // Bits needed to index n channels (ceil(log2(n))).
    function automatic int ch_w(input int n);
        for (int w = 0; w < 31; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 31;
    endfunction

    typedef logic [DEF_CNT_W-1:0]          cnt_t;
    typedef logic [ch_w(DEF_NUM_CH)-1:0]   ch_idx_t;

endpackage

// File: rtl/pulse_qual_chan.sv
// One channel: saturating high-time counter, programmable threshold register and
// the single-cycle qualify strobe.
module pulse_qual_chan
    import pulse_qual_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_THRESH = DEF_THRESH_100M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic             q
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thresh;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            thresh <= CNT_W'(DEF_THRESH);
        end else begin
            if (we) thresh <= wdata;
            if (!sig)
                cnt <= '0;
            else if (cnt < thresh)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the edge sampling the thresh-th consecutive high; the counter then
    // saturates at thresh, so the strobe cannot repeat within one high period.
    assign q = sig && (thresh != '0) && (cnt == thresh - CNT_W'(1));

endmodule

// File: rtl/pulse_qual_sched.sv
// Multi-channel pulse qualifier: per-channel qualifiers feed pending bits that a
// round-robin arbiter drains into a one-entry valid/ready output register.
module pulse_qual_sched
    import pulse_qual_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int CNT_W      = DEF_CNT_W,
    parameter  int DEF_THRESH = DEF_THRESH_100M,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              ovf_clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic [NUM_CH-1:0] ovf
);

    logic [NUM_CH-1:0] q_vec;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] grant_mask;
    logic [NUM_CH-1:0] ovf_set;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   winner;
    logic              found;
    logic              grant;

    // Addresses at or above NUM_CH match no instance, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pulse_qual_chan #(
            .CNT_W      (CNT_W),
            .DEF_THRESH (DEF_THRESH)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .sig   (sig_in[i]),
            .we    (cfg_we && (cfg_ch == CH_W'(i))),
            .wdata (cfg_thresh),
            .q     (q_vec[i])
        );
    end

    // NOTE: every combinational output gets a default before the loop, otherwise
    // paths that skip an assignment would infer latches.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && pending[idx]) begin
                winner = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign grant = found && (!evt_valid || evt_ready);

    // A qualify on the channel being granted this cycle re-arms pending instead
    // of overflowing.
    always_comb begin
        grant_mask = '0;
        if (grant) grant_mask[winner] = 1'b1;
        ovf_set     = q_vec & pending & ~grant_mask;
        pending_nxt = (pending & ~grant_mask) | q_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ovf       <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            pending <= pending_nxt;
            ovf     <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_set;
            if (grant) begin
                evt_valid <= 1'b1;
                evt_ch    <= winner;
                rr_ptr    <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
